// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fft_pkg;

   localparam int N_FFT    = 512;
   localparam int NUM_LANE = 16;
   localparam int LOG2N    = 9;
   localparam int SAMPLE_W = 18;

   // One input block carries NUM_LANE samples, so a frame is N_BLK blocks.
   localparam int N_BLK  = N_FFT / NUM_LANE;
   localparam int BLK_W  = $clog2(N_BLK);
   localparam int LANE_W = $clog2(NUM_LANE);

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] re;
      logic signed [SAMPLE_W-1:0] im;
   } sample_t;

   typedef enum logic {WR_FILL, WR_DROP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

   // Reverse the 9-bit sample index (radix-2 output order <-> natural order).
   function automatic logic [LOG2N-1:0] bitrev9(input logic [LOG2N-1:0] n);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = n[LOG2N-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One 512-entry frame bank: 16-lane scattered write per block, single registered read port.
// Latency: read data appears one cycle after rd_en; write is visible on the following cycle.
// Backpressure: none; rd_en low holds rd_dat, which is what keeps the output stable during stalls.
module fft_reorder_bank
   import fft_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we,
   input  logic [BLK_W-1:0]       blk,
   input  sample_t [NUM_LANE-1:0] wdat,
   input  logic                   rd_en,
   input  logic [LOG2N-1:0]       rd_addr,
   output sample_t                rd_dat
);

   sample_t mem [N_FFT];

   // Lane j of block blk is sample n = {blk, j}; it lands at bitrev9(n) so the bank reads out in natural order.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int j = 0; j < NUM_LANE; j++) begin
            mem[bitrev9({blk, LANE_W'(j)})] <= wdat[j];
         end
      end
   end

   // Registered read port; doubles as the output data register of the block.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_dat <= '0;
      end else if (rd_en) begin
         rd_dat <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/fft_out_reorder.sv
// Bit-reversed 16-lane FFT block stream in, natural-order one-sample-per-cycle stream out, via ping-pong banks.
// Latency: block 31 strobed in cycle c -> bin 0 presented with dout_valid in cycle c+2.
// Backpressure: dout_ready stalls the reader only; the producer is never stalled, a frame with no free bank is dropped (sticky overflow).
module fft_out_reorder
   import fft_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W,
   parameter int NUM   = NUM_LANE,
   parameter int DATA  = N_FFT
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM*WIDTH-1:0]    din_i,
   input  logic [NUM*WIDTH-1:0]    din_q,
   input  logic                    valid_in,
   output logic signed [WIDTH-1:0] dout_re,
   output logic signed [WIDTH-1:0] dout_im,
   output logic [LOG2N-1:0]        dout_idx,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic                    dout_last,
   output logic                    overflow
);

   localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(N_BLK - 1);
   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(DATA - 1);

   wr_state_t              wr_state;
   rd_state_t              rd_state;
   logic                   wr_bank;
   logic                   rd_bank;
   logic                   rd_sel;
   logic [BLK_W-1:0]       blk;
   logic [1:0]             full;
   sample_t [NUM_LANE-1:0] wdat;
   sample_t                rd_dat [2];

   logic                   xfer;
   logic                   last_xfer;
   logic                   target_busy;
   logic                   start_drop;
   logic                   do_write;
   logic                   frame_done;
   logic                   ld_en;
   logic                   ld_bank;
   logic [LOG2N-1:0]       ld_addr;

   // Unpack the flat lane buses into per-lane samples.
   always_comb begin
      wdat = '0;
      for (int j = 0; j < NUM_LANE; j++) begin
         wdat[j].re = din_i[j*WIDTH +: WIDTH];
         wdat[j].im = din_q[j*WIDTH +: WIDTH];
      end
   end

   assign xfer      = dout_valid && dout_ready;
   assign last_xfer = xfer && (dout_idx == LAST_IDX);

   // A bank released by the reader on this very edge counts as free for a frame starting now.
   assign target_busy = full[wr_bank] && !(last_xfer && (rd_bank == wr_bank));
   assign start_drop  = valid_in && (wr_state == WR_FILL) && (blk == '0) && target_busy;
   assign do_write    = valid_in && (wr_state == WR_FILL) && !start_drop;
   assign frame_done  = do_write && (blk == LAST_BLK);

   // Writer: block counter runs in both states so a dropped frame keeps the block alignment.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state <= WR_FILL;
         wr_bank  <= 1'b0;
         blk      <= '0;
         overflow <= 1'b0;
      end else if (valid_in) begin
         blk <= blk + 1'b1;
         if (start_drop) begin
            wr_state <= WR_DROP;
            overflow <= 1'b1;
         end else if ((wr_state == WR_DROP) && (blk == LAST_BLK)) begin
            wr_state <= WR_FILL;
         end
         if (frame_done) begin
            wr_bank <= ~wr_bank;
         end
      end
   end

   // Bank full flags: set by the writer on its last block, cleared by the reader on bin 511.
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (frame_done && (wr_bank == 1'(b))) begin
               full[b] <= 1'b1;
            end else if (last_xfer && (rd_bank == 1'(b))) begin
               full[b] <= 1'b0;
            end
         end
      end
   end

   // Reader next-sample selection: which bank/address to load into the output register this edge.
   always_comb begin
      ld_en   = 1'b0;
      ld_bank = rd_bank;
      ld_addr = '0;
      case (rd_state)
         RD_IDLE: begin
            ld_en = full[rd_bank];
         end
         RD_STREAM: begin
            if (xfer) begin
               if (last_xfer) begin
                  // Chain straight into the other bank when it already holds a frame.
                  ld_en   = full[~rd_bank];
                  ld_bank = ~rd_bank;
               end else begin
                  ld_en   = 1'b1;
                  ld_addr = dout_idx + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Reader state and registered index/last; everything holds when nothing is loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state  <= RD_IDLE;
         rd_bank   <= 1'b0;
         rd_sel    <= 1'b0;
         dout_idx  <= '0;
         dout_last <= 1'b0;
      end else begin
         if (last_xfer) begin
            rd_bank <= ~rd_bank;
         end
         if (ld_en) begin
            rd_state  <= RD_STREAM;
            rd_sel    <= ld_bank;
            dout_idx  <= ld_addr;
            dout_last <= (ld_addr == LAST_IDX);
         end else if (last_xfer) begin
            rd_state  <= RD_IDLE;
            dout_last <= 1'b0;
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_reorder_bank u_bank (
         .clk     (clk),
         .rst     (rst),
         .we      (do_write && (wr_bank == 1'(b))),
         .blk     (blk),
         .wdat    (wdat),
         .rd_en   (ld_en && (ld_bank == 1'(b))),
         .rd_addr (ld_addr),
         .rd_dat  (rd_dat[b])
      );
   end

   assign dout_valid = (rd_state == RD_STREAM);
   assign dout_re    = rd_sel ? rd_dat[1].re : rd_dat[0].re;
   assign dout_im    = rd_sel ? rd_dat[1].im : rd_dat[0].im;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: ramp frames, stalls, drop/overflow, free-on-fill edge, resets, extremes.
// Expected values come from a local bit-reversal model of the ramp stimulus.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_fft_out_reorder;

   localparam int W = 18;
   localparam int L = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic [L*W-1:0]      din_i;
   logic [L*W-1:0]      din_q;
   logic                valid_in;
   logic signed [W-1:0] dout_re;
   logic signed [W-1:0] dout_im;
   logic [8:0]          dout_idx;
   logic                dout_valid;
   logic                dout_ready;
   logic                dout_last;
   logic                overflow;

   int checks = 0;
   int errors = 0;

   fft_out_reorder dut (
      .clk        (clk),
      .rst        (rst),
      .din_i      (din_i),
      .din_q      (din_q),
      .valid_in   (valid_in),
      .dout_re    (dout_re),
      .dout_im    (dout_im),
      .dout_idx   (dout_idx),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   function automatic int rev9(int n);
      int r = 0;
      for (int i = 0; i < 9; i++) begin
         if (n[i]) r = r | (1 << (8 - i));
      end
      return r;
   endfunction

   function automatic int exp_re(int base, int k, bit ext);
      return ext ? -131072 : base + rev9(k);
   endfunction

   function automatic int exp_im(int base, int k, bit ext);
      return ext ? 131071 : -(base + rev9(k));
   endfunction

   task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_block(int base, int b, bit ext);
      int n;
      for (int j = 0; j < L; j++) begin
         n = b * L + j;
         din_i[j*W +: W] = ext ? W'(-131072) : W'(base + n);
         din_q[j*W +: W] = ext ? W'(131071) : W'(-(base + n));
      end
   endtask

   task automatic drive_block(int base, int b, bit ext);
      set_block(base, b, ext);
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
   endtask

   task automatic send_frame(int base, bit ext);
      for (int b = 0; b < 32; b++) drive_block(base, b, ext);
   endtask

   // Drain n samples; frame f of the stream is expected to carry base0 + f*step.
   task automatic collect(int n, int base0, int step, bit ext, bit rnd);
      int got;
      int budget;
      int k;
      int base;
      got    = 0;
      budget = n * 4 + 200;
      while (got < n && budget > 0) begin
         dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (dout_valid) begin
            k    = got % 512;
            base = base0 + (got / 512) * step;
            chk("stream_idx", dout_idx, k);
            chk("stream_re", dout_re, exp_re(base, k, ext));
            if (dout_ready) begin
               chk("stream_im", dout_im, exp_im(base, k, ext));
               chk("stream_last", dout_last, k == 511);
               got++;
            end
         end
         tick();
         budget--;
      end
      chk("xfer_count", got, n);
      dout_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst        = 1'b1;
      valid_in   = 1'b0;
      dout_ready = 1'b0;
      din_i      = '0;
      din_q      = '0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_valid", dout_valid, 0);
      chk("rst_re", dout_re, 0);
      chk("rst_im", dout_im, 0);
      chk("rst_idx", dout_idx, 0);
      chk("rst_last", dout_last, 0);
      chk("rst_overflow", overflow, 0);
      tick();
      rst = 1'b0;

      // Single ramp frame: latency to bin 0, then full natural-order readout.
      send_frame(0, 1'b0);
      @(negedge clk);
      chk("lat_c1_valid", dout_valid, 0);
      @(negedge clk);
      chk("lat_c2_valid", dout_valid, 1);
      chk("lat_c2_idx", dout_idx, 0);
      tick();
      collect(512, 0, 0, 1'b0, 1'b0);
      chk("t1_overflow", overflow, 0);

      // Random backpressure over one frame.
      send_frame(1000, 1'b0);
      collect(512, 1000, 0, 1'b0, 1'b1);

      // Three frames with the output stalled: third frame dropped.
      send_frame(2000, 1'b0);
      send_frame(3000, 1'b0);
      send_frame(4000, 1'b0);
      @(negedge clk);
      chk("t3_overflow", overflow, 1);
      chk("t3_stalled_idx", dout_idx, 0);
      tick();
      collect(1024, 2000, 1000, 1'b0, 1'b0);
      repeat (3) tick();
      @(negedge clk);
      chk("t3_drained", dout_valid, 0);
      tick();
      send_frame(5000, 1'b0);
      collect(512, 5000, 0, 1'b0, 1'b0);

      // Reset at input block 17 while the output is mid-stream.
      send_frame(6000, 1'b0);
      dout_ready = 1'b1;
      for (int b = 0; b < 17; b++) drive_block(7000, b, 1'b0);
      rst = 1'b1;
      drive_block(7000, 17, 1'b0);
      rst        = 1'b0;
      dout_ready = 1'b0;
      @(negedge clk);
      chk("t5_valid", dout_valid, 0);
      chk("t5_re", dout_re, 0);
      chk("t5_im", dout_im, 0);
      chk("t5_idx", dout_idx, 0);
      chk("t5_last", dout_last, 0);
      chk("t5_overflow", overflow, 0);
      repeat (3) tick();
      @(negedge clk);
      chk("t5_empty", dout_valid, 0);
      tick();
      send_frame(8000, 1'b0);
      collect(512, 8000, 0, 1'b0, 1'b0);

      // Both banks full; bin 511 transfer coincides with block 0 of the next frame.
      send_frame(9000, 1'b0);
      send_frame(10000, 1'b0);
      collect(511, 9000, 0, 1'b0, 1'b0);
      set_block(11000, 0, 1'b0);
      valid_in   = 1'b1;
      dout_ready = 1'b1;
      @(negedge clk);
      chk("t4_idx511", dout_idx, 511);
      chk("t4_last", dout_last, 1);
      chk("t4_re511", dout_re, 9511);
      tick();
      valid_in   = 1'b0;
      dout_ready = 1'b0;
      @(negedge clk);
      chk("t4_nobubble_valid", dout_valid, 1);
      chk("t4_nobubble_idx", dout_idx, 0);
      chk("t4_nobubble_re", dout_re, 10000);
      tick();
      for (int b = 1; b < 32; b++) drive_block(11000, b, 1'b0);
      @(negedge clk);
      chk("t4_overflow", overflow, 0);
      tick();
      collect(1024, 10000, 1000, 1'b0, 1'b0);

      // Full-scale extremes pass through bit-exact.
      send_frame(0, 1'b1);
      collect(512, 0, 0, 1'b1, 1'b0);
      @(negedge clk);
      chk("t6_overflow", overflow, 0);
      chk("t6_idle", dout_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
